// File: rtl/program_memory.sv
// -----------------------------------------------------------------------------
// program_memory
//
// Loadable instruction store for the single-cycle core. After reset the array
// is filled through a valid/ready stream; the core is held until the load
// completes, then fetches are served word-addressed from a byte PC.
//
// Parameters
//   DATA_W   instruction width in bits
//   ADDR_W   width of the fetch byte address
//   DEPTH    number of words (power of two, >= 2)
//   REG_OUT  0: combinational fetch, 1: registered fetch (one-cycle latency)
//
// Ports
//   clk, rst_n    clock (rising edge) and asynchronous active-low reset
//   fetch_addr    byte address from the PC
//   instr         fetched instruction, 0 when not a legal fetch in RUN
//   instr_valid   instr is a legal fetch in RUN
//   fault         RUN fetch is misaligned or beyond the loaded program
//   core_hold     stalls the PC while not running
//   load_start    begin or restart a program load
//   load_valid    load_data is presented
//   load_data     program word
//   load_last     final word of the program
//   load_ready    loader accepts a word this cycle
//   load_done     one-cycle pulse on the first RUN cycle
//   load_count    number of words written by the last load
// -----------------------------------------------------------------------------
module program_memory #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 32,
    parameter int DEPTH   = 64,
    parameter int REG_OUT = 0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [ADDR_W-1:0]        fetch_addr,
    output logic [DATA_W-1:0]        instr,
    output logic                     instr_valid,
    output logic                     fault,
    output logic                     core_hold,
    input  logic                     load_start,
    input  logic                     load_valid,
    input  logic [DATA_W-1:0]        load_data,
    input  logic                     load_last,
    output logic                     load_ready,
    output logic                     load_done,
    output logic [$clog2(DEPTH):0]   load_count
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = IDX_W + 1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOAD = 2'd1;
    localparam logic [1:0] ST_RUN  = 2'd2;

    // -------------------------------------------------------------------------
    // Loader state
    // -------------------------------------------------------------------------
    logic [1:0]       state_q,      state_d;
    logic [IDX_W-1:0] ptr_q,        ptr_d;
    logic [CNT_W-1:0] load_count_q, load_count_d;
    logic             load_done_q,  load_done_d;
    logic             wr_en;

    // NOTE: every variable assigned here gets a default first, so no path
    // through the case leaves one unassigned and no latch is inferred.
    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        load_count_d = load_count_q;
        wr_en        = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (load_start) begin
                    state_d      = ST_LOAD;
                    ptr_d        = '0;
                    load_count_d = '0;
                end
            end
            ST_LOAD: begin
                // A restart takes priority over a word presented alongside it.
                if (load_start) begin
                    ptr_d        = '0;
                    load_count_d = '0;
                end else if (load_valid) begin
                    wr_en        = 1'b1;
                    ptr_d        = ptr_q + IDX_W'(1);
                    load_count_d = load_count_q + CNT_W'(1);
                    // Filling the last slot ends the load even without load_last.
                    if (load_last || (ptr_q == IDX_W'(DEPTH - 1))) begin
                        state_d = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                if (load_start) begin
                    state_d      = ST_LOAD;
                    ptr_d        = '0;
                    load_count_d = '0;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        load_done_d = (state_q == ST_LOAD) && (state_d == ST_RUN);
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            ptr_q        <= '0;
            load_count_q <= '0;
            load_done_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            load_count_q <= load_count_d;
            load_done_q  <= load_done_d;
        end
    end

    // -------------------------------------------------------------------------
    // Word array
    // -------------------------------------------------------------------------
    logic [DATA_W-1:0] mem [DEPTH];

    // NOTE: the array has no reset; stale words past load_count can never be
    // fetched because such fetches fault, so clearing it would buy nothing.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[ptr_q] <= load_data;
        end
    end

    // -------------------------------------------------------------------------
    // Fetch decode
    // -------------------------------------------------------------------------
    logic [ADDR_W-1:0] word_addr;
    logic [IDX_W-1:0]  fetch_idx;
    logic              run;
    logic              legal;
    logic [DATA_W-1:0] instr_d;
    logic              instr_valid_d;
    logic              fault_d;

    // The full word address is compared against load_count so any set upper
    // bit lands out of range, not aliased into the array.
    assign word_addr = {2'b00, fetch_addr[ADDR_W-1:2]};
    assign fetch_idx = fetch_addr[IDX_W+1:2];
    assign run       = (state_q == ST_RUN);

    always_comb begin
        legal         = run && (fetch_addr[1:0] == 2'b00)
                            && (word_addr < ADDR_W'(load_count_q));
        instr_d       = legal ? mem[fetch_idx] : '0;
        instr_valid_d = legal;
        fault_d       = run && !legal;
    end

    generate
        if (REG_OUT != 0) begin : g_reg_out
            logic [DATA_W-1:0] instr_q;
            logic              instr_valid_q;
            logic              fault_q;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    instr_q       <= '0;
                    instr_valid_q <= 1'b0;
                    fault_q       <= 1'b0;
                end else begin
                    instr_q       <= instr_d;
                    instr_valid_q <= instr_valid_d;
                    fault_q       <= fault_d;
                end
            end

            assign instr       = instr_q;
            assign instr_valid = instr_valid_q;
            assign fault       = fault_q;
            // The first RUN cycle still shows the pre-RUN registered outputs,
            // so the PC is held one more cycle until a real fetch lands.
            assign core_hold   = !run || load_done_q;
        end else begin : g_comb_out
            assign instr       = instr_d;
            assign instr_valid = instr_valid_d;
            assign fault       = fault_d;
            assign core_hold   = !run;
        end
    endgenerate

    assign load_ready = (state_q == ST_LOAD);
    assign load_done  = load_done_q;
    assign load_count = load_count_q;

endmodule

// File: tb/tb_program_memory.sv
// -----------------------------------------------------------------------------
// tb_program_memory
//
// Drives three program_memory instances from one shared stimulus stream:
//   d_*  DEPTH=64, combinational fetch
//   e_*  DEPTH=8,  combinational fetch (implicit-last behaviour)
//   r_*  DEPTH=64, registered fetch
// Inputs change 1 ns after a rising edge; outputs are checked before the next.
// -----------------------------------------------------------------------------
module tb_program_memory;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] fetch_addr;
    logic        load_start;
    logic        load_valid;
    logic [31:0] load_data;
    logic        load_last;

    logic [31:0] d_instr, e_instr, r_instr;
    logic        d_valid, e_valid, r_valid;
    logic        d_fault, e_fault, r_fault;
    logic        d_hold,  e_hold,  r_hold;
    logic        d_ready, e_ready, r_ready;
    logic        d_done,  e_done,  r_done;
    logic [6:0]  d_count, r_count;
    logic [3:0]  e_count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    program_memory #(.DATA_W(32), .ADDR_W(32), .DEPTH(64), .REG_OUT(0)) u_d64 (
        .clk(clk), .rst_n(rst_n), .fetch_addr(fetch_addr),
        .instr(d_instr), .instr_valid(d_valid), .fault(d_fault), .core_hold(d_hold),
        .load_start(load_start), .load_valid(load_valid), .load_data(load_data),
        .load_last(load_last), .load_ready(d_ready), .load_done(d_done),
        .load_count(d_count)
    );

    program_memory #(.DATA_W(32), .ADDR_W(32), .DEPTH(8), .REG_OUT(0)) u_d8 (
        .clk(clk), .rst_n(rst_n), .fetch_addr(fetch_addr),
        .instr(e_instr), .instr_valid(e_valid), .fault(e_fault), .core_hold(e_hold),
        .load_start(load_start), .load_valid(load_valid), .load_data(load_data),
        .load_last(load_last), .load_ready(e_ready), .load_done(e_done),
        .load_count(e_count)
    );

    program_memory #(.DATA_W(32), .ADDR_W(32), .DEPTH(64), .REG_OUT(1)) u_r64 (
        .clk(clk), .rst_n(rst_n), .fetch_addr(fetch_addr),
        .instr(r_instr), .instr_valid(r_valid), .fault(r_fault), .core_hold(r_hold),
        .load_start(load_start), .load_valid(load_valid), .load_data(load_data),
        .load_last(load_last), .load_ready(r_ready), .load_done(r_done),
        .load_count(r_count)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n      = 1'b0;
        fetch_addr = '0;
        load_start = 1'b0;
        load_valid = 1'b0;
        load_data  = '0;
        load_last  = 1'b0;

        // ---- reset values ----
        #3;
        check("rst_hold",   32'(d_hold),  32'd1);
        check("rst_ready",  32'(d_ready), 32'd0);
        check("rst_done",   32'(d_done),  32'd0);
        check("rst_count",  32'(d_count), 32'd0);
        check("rst_instr",  d_instr,      32'd0);
        check("rst_valid",  32'(d_valid), 32'd0);
        check("rst_fault",  32'(d_fault), 32'd0);
        check("rst_r_hold", 32'(r_hold),  32'd1);
        #4;
        rst_n = 1'b1;
        tick();

        // ---- IDLE ignores load_valid ----
        load_valid = 1'b1;
        load_data  = 32'h1111_1111;
        tick();
        check("idle_ready", 32'(d_ready), 32'd0);
        check("idle_count", 32'(d_count), 32'd0);

        // ---- start load ----
        load_valid = 1'b0;
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        check("load_ready", 32'(d_ready), 32'd1);
        check("load_hold",  32'(d_hold),  32'd1);

        // ---- 16 words, 3-cycle gap after word 5, load_last on word 16 ----
        for (int i = 0; i < 16; i++) begin
            load_valid = 1'b1;
            load_data  = 32'h2404_0000 + 32'(i);
            load_last  = (i == 15);
            tick();
            if (i == 5) begin
                load_valid = 1'b0;
                load_data  = 32'hFFFF_FFFF;
                tick();
                tick();
                tick();
                check("gap_count",   32'(d_count), 32'd6);
                check("gap_count8",  32'(e_count), 32'd6);
            end
        end
        load_valid = 1'b0;
        load_last  = 1'b0;

        // first RUN cycle
        check("done_pulse",  32'(d_done),  32'd1);
        check("count16",     32'(d_count), 32'd16);
        check("run_hold",    32'(d_hold),  32'd0);
        check("run_ready",   32'(d_ready), 32'd0);
        check("r_done",      32'(r_done),  32'd1);
        check("r_hold_ext",  32'(r_hold),  32'd1);
        check("r_valid_pre", 32'(r_valid), 32'd0);
        check("d8_count",    32'(e_count), 32'd8);
        check("d8_hold",     32'(e_hold),  32'd0);
        fetch_addr = 32'h3C;
        #1;
        check("fetch_3c",     d_instr,      32'h2404_000F);
        check("fetch_3c_val", 32'(d_valid), 32'd1);
        check("fetch_3c_flt", 32'(d_fault), 32'd0);
        check("d8_3c_fault",  32'(e_fault), 32'd1);
        check("d8_3c_instr",  e_instr,      32'd0);

        tick();
        check("done_once",  32'(d_done),  32'd0);
        check("r_hold_rel", 32'(r_hold),  32'd0);
        check("r_3c",       r_instr,      32'h2404_000F);
        check("r_3c_valid", 32'(r_valid), 32'd1);

        // ---- index == load_count ----
        fetch_addr = 32'h40;
        #1;
        check("f40_instr",  d_instr,      32'd0);
        check("f40_fault",  32'(d_fault), 32'd1);
        check("f40_valid",  32'(d_valid), 32'd0);
        check("r_latency",  r_instr,      32'h2404_000F);
        tick();
        check("r40_fault",  32'(r_fault), 32'd1);
        check("r40_instr",  r_instr,      32'd0);

        // ---- misaligned ----
        fetch_addr = 32'h06;
        #1;
        check("f06_instr",  d_instr,      32'd0);
        check("f06_fault",  32'(d_fault), 32'd1);
        check("f06_valid",  32'(d_valid), 32'd0);

        // ---- contents across the gap, and the DEPTH=8 boundary ----
        fetch_addr = 32'h1C;
        #1;
        check("f1c",        d_instr, 32'h2404_0007);
        check("d8_f1c",     e_instr, 32'h2404_0007);
        fetch_addr = 32'h18;
        #1;
        check("f18",        d_instr, 32'h2404_0006);
        fetch_addr = 32'h20;
        #1;
        check("f20",        d_instr,      32'h2404_0008);
        check("d8_f20_flt", 32'(e_fault), 32'd1);

        // ---- upper address bits out of range ----
        fetch_addr = 32'h0000_1000;
        #1;
        check("upper_fault", 32'(d_fault), 32'd1);
        check("upper_instr", d_instr,      32'd0);

        // ---- writes ignored in RUN ----
        tick();
        load_valid = 1'b1;
        load_data  = 32'hDEAD_BEEF;
        tick();
        load_valid = 1'b0;
        fetch_addr = 32'h0;
        #1;
        check("run_nowrite", d_instr,      32'h2404_0000);
        check("run_nocount", 32'(d_count), 32'd16);

        // ---- load_start with load_valid in RUN ----
        tick();
        load_start = 1'b1;
        load_valid = 1'b1;
        load_data  = 32'hBAD0_0000;
        tick();
        check("rl_hold",  32'(d_hold),  32'd1);
        check("rl_ready", 32'(d_ready), 32'd1);
        check("rl_count", 32'(d_count), 32'd0);
        check("rl_valid", 32'(d_valid), 32'd0);

        // ---- load_start with load_valid in LOAD ----
        load_data = 32'hBAD1_0000;
        tick();
        load_start = 1'b0;
        check("ll_count", 32'(d_count), 32'd0);
        check("ll_hold",  32'(d_hold),  32'd1);

        for (int i = 0; i < 4; i++) begin
            load_valid = 1'b1;
            load_data  = 32'hA000_0000 + 32'(i);
            load_last  = (i == 3);
            tick();
            if (i == 1) check("rl_mid_count", 32'(d_count), 32'd2);
        end
        load_valid = 1'b0;
        load_last  = 1'b0;
        check("rl_done",    32'(d_done),  32'd1);
        check("rl_count4",  32'(d_count), 32'd4);
        check("rl_count8",  32'(e_count), 32'd4);
        fetch_addr = 32'h0;
        #1;
        check("rl_f00",     d_instr, 32'hA000_0000);
        fetch_addr = 32'hC;
        #1;
        check("rl_f0c",     d_instr, 32'hA000_0003);
        check("rl_d8_f0c",  e_instr, 32'hA000_0003);
        fetch_addr = 32'h10;
        #1;
        check("rl_f10_flt", 32'(d_fault), 32'd1);
        check("rl_f10_ins", d_instr,      32'd0);

        // ---- asynchronous reset mid-load ----
        tick();
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            load_valid = 1'b1;
            load_data  = 32'hC000_0000 + 32'(i);
            tick();
        end
        load_valid = 1'b0;
        check("ml_count", 32'(d_count), 32'd2);
        #2;
        rst_n = 1'b0;
        #1;
        check("ar_count",  32'(d_count), 32'd0);
        check("ar_ready",  32'(d_ready), 32'd0);
        check("ar_hold",   32'(d_hold),  32'd1);
        check("ar_done",   32'(d_done),  32'd0);
        check("ar_fault",  32'(d_fault), 32'd0);
        check("ar_r_hold", 32'(r_hold),  32'd1);
        check("ar_r_inst", r_instr,      32'd0);
        check("ar_r_val",  32'(r_valid), 32'd0);
        check("ar_r_cnt",  32'(r_count), 32'd0);
        #3;
        rst_n = 1'b1;
        tick();
        check("post_idle_ready", 32'(d_ready), 32'd0);
        check("post_idle_hold",  32'(d_hold),  32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/program_memory.md
# program_memory

Parametrised, loadable instruction memory for the single-cycle processor. It replaces the fixed, hard-coded program store with a word array of configurable depth. A sequential loader fills the array through a valid/ready stream after reset, and the core is held until loading finishes. Fetch is word-addressed from a byte PC, with an optional registered read port and a fault flag for illegal fetches.

## Interface
- DATA_W, 32, instruction width in bits
- ADDR_W, 32, width of the fetch byte address
- DEPTH, 64, number of words; must be a power of two, ≥ 2
- REG_OUT, 0, 0 = combinational fetch (single-cycle core); 1 = registered fetch (one-cycle latency)

- clk  in  1  clock; all state updates on the rising edge
- rst_n  in  1  asynchronous, active-low reset
- fetch_addr  in  ADDR_W  byte address from the PC
- instr  out  DATA_W  fetched instruction; 0 (NOP) when not valid
- instr_valid  out  1  instr is a legal fetch in RUN state
- fault  out  1  fetch is misaligned (addr[1:0]≠0) or has index ≥ load_count
- core_hold  out  1  high whenever state ≠ RUN; stalls the PC
- load_start  in  1  begin (or restart) a program load
- load_valid  in  1  load_data is presented
- load_data  in  DATA_W  program word
- load_last  in  1  qualifies the final word of the program
- load_ready  out  1  loader accepts a word this cycle
- load_done  out  1  one-cycle pulse when the loader enters RUN
- load_count  out  $clog2(DEPTH)+1  number of words written in the last load

## Operation
- States: IDLE (reset state), LOAD, RUN.
- IDLE → LOAD on load_start. All other inputs are ignored in IDLE.
- LOAD:
  - load_ready = 1.
  - A word is accepted when load_valid & load_ready at the edge. It is written to mem[ptr], and ptr and load_count each increment.
  - LOAD → RUN after the edge that accepts a word with load_last=1, or that accepts the word at ptr = DEPTH−1 (implicit last).
  - load_done pulses for the first RUN cycle.
- load_start while in LOAD or RUN: next state is LOAD, ptr = 0, load_count = 0.
  - If load_start and load_valid are high in the same LOAD cycle, load_start wins and the word is dropped.
- RUN:
  - load_ready = 0, and load_valid is ignored (no writes, no overflow).
  - Fetch index is fetch_addr[$clog2(DEPTH)+1:2]. Upper address bits beyond the array are treated as out of range: index ≥ DEPTH gives fault.
  - Legal fetch: instr = mem[index], instr_valid = 1, fault = 0.
  - Illegal fetch (misaligned, or index ≥ load_count): instr = 0, instr_valid = 0, fault = 1.
- Outside RUN: instr = 0, instr_valid = 0, fault = 0, core_hold = 1.
- Array contents are not cleared by reset. Words beyond load_count are unreachable because such fetches fault.

## Timing
- Reset values: state IDLE, ptr 0, load_count 0, load_ready 0, load_done 0, core_hold 1, instr 0, instr_valid 0, fault 0. The REG_OUT output register also resets to 0.
- Reset asserted mid-load aborts the load immediately. State returns to IDLE and the core stays held.
- Write latency: a word accepted at edge N is readable by a fetch in RUN from cycle N+1 onward.
- REG_OUT=0: instr, instr_valid and fault are combinational from fetch_addr and state.
- REG_OUT=1: those three outputs are registered, giving one-cycle fetch latency.
  - core_hold also stays high for one extra cycle after entering RUN, so the first registered fetch is valid.
- load_ready is a registered state decode with no combinational path from load_valid.
- Maximum load of DEPTH words takes DEPTH accepting cycles plus one transition cycle.

## Test plan
- Reset, pulse load_start, stream 16 words 0x24040000… with load_last on word 16. Expect load_count = 16, load_done pulses once, core_hold falls, and fetch 0x3C returns word 16 with instr_valid = 1.
- After that load, fetch 0x40 (index 16 = load_count) and fetch 0x06 (misaligned). Expect instr = 0, fault = 1 and instr_valid = 0 for each.
- With DEPTH=8, stream 10 words with no load_last. Expect the implicit last at word 8, RUN entered, words 9–10 ignored, and load_count = 8.
- Gap load_valid low for 3 cycles mid-stream. Expect ptr to hold and no spurious writes; the resulting contents must match the no-gap load.
- Assert load_start together with load_valid in LOAD, and separately in RUN. Expect ptr = 0, the word dropped, the core held, and the reload overwriting from index 0.
- REG_OUT=1: expect fetch data one cycle after address and core_hold released one cycle after load_done. Assert rst_n low mid-load: expect all outputs at reset values asynchronously.
